// File: rtl/viterbi_pkg.sv
// Shared constants and types for the convolutional code path (encoder, branch metric, traceback).
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents:
//   K, SYM_W          constraint length and encoded symbol width
//   G0_DEFAULT/G1_DEFAULT default generator polynomials (bit K-1 = current input, bit0 = oldest)
//   enc_state_e       encoder framer FSM states
//   poly_tap()        parity of a generator applied to the encoder window
package viterbi_pkg;

  localparam int K     = 3;
  localparam int SYM_W = 2;

  localparam logic [K-1:0] G0_DEFAULT = 3'b111;
  localparam logic [K-1:0] G1_DEFAULT = 3'b101;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    WAIT  = 2'd2,
    TAIL  = 2'd3
  } enc_state_e;

  // Window layout is {u, s1, s2}: current input bit first, oldest bit last.
  function automatic logic poly_tap(input logic [K-1:0] g, input logic [K-1:0] window);
    return ^(g & window);
  endfunction

endpackage

// File: rtl/conv_enc_core.sv
// K=3 rate-1/2 encoder core: two-bit memory plus the generator parity taps.
// Latency: symbol is combinational from bit_in and the memory; memory updates on the adv edge.
// Backpressure: none internally; memory only moves when the caller asserts adv.
//
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset (memory clears to 00)
//   bit_in      next payload bit (u)
//   zero_in     forces u to 0 for the tail bits
//   adv         shift the memory: s2 <= s1, s1 <= u
//   sym         {G0 parity, G1 parity} over {u, s1, s2}
module conv_enc_core
  import viterbi_pkg::*;
#(
  parameter logic [K-1:0] G0 = G0_DEFAULT,
  parameter logic [K-1:0] G1 = G1_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bit_in,
  input  logic             zero_in,
  input  logic             adv,
  output logic [SYM_W-1:0] sym
);

  logic s1;
  logic s2;
  logic u;
  logic [K-1:0] window;

  assign u      = zero_in ? 1'b0 : bit_in;
  assign window = {u, s1, s2};
  assign sym    = {poly_tap(G0, window), poly_tap(G1, window)};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else if (adv) begin
      s2 <= s1;
      s1 <= u;
    end
  end

endmodule

// File: rtl/conv_encoder_framer.sv
// Frames payload bytes into K=3 rate-1/2 encoded symbols, MSB first, with two zero tail bits per frame.
// Latency: first symbol valid the cycle after the first byte is accepted; one symbol per accepted bit.
// Backpressure: sym_ready=0 freezes all state and sym_out; in_ready is low while bits are still shifting.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset (mid-frame reset drops the frame)
//   in_data/in_valid/in_ready  payload byte handshake
//   sym_out/sym_valid/sym_ready encoded symbol handshake, {G0 out, G1 out}
//   sym_sof/sym_eof            first payload symbol / last tail symbol of a frame
//   busy                       FSM is not idle
module conv_encoder_framer
  import viterbi_pkg::*;
#(
  parameter int           FRAME_BYTES = 4,
  parameter logic [K-1:0] G0          = G0_DEFAULT,
  parameter logic [K-1:0] G1          = G1_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sym_ready,
  output logic [SYM_W-1:0] sym_out,
  output logic             sym_valid,
  output logic             sym_sof,
  output logic             sym_eof,
  output logic             busy
);

  localparam int BCW = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;
  localparam logic [BCW-1:0] LAST_BYTE = BCW'(FRAME_BYTES - 1);

  enc_state_e     state_q, state_d;
  logic [7:0]     sr_q, sr_d;
  logic [2:0]     bit_cnt_q, bit_cnt_d;
  logic [BCW-1:0] byte_cnt_q, byte_cnt_d;

  logic in_ready_fsm;
  logic enc_adv;
  logic in_tail;

  // ---------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sr_q       <= '0;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
    end
  end

  // ---------------------------------------------------------------------
  // Next-state and handshake decode
  // ---------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    sr_d         = sr_q;
    bit_cnt_d    = bit_cnt_q;
    byte_cnt_d   = byte_cnt_q;
    in_ready_fsm = 1'b0;
    enc_adv      = 1'b0;

    unique case (state_q)
      IDLE: begin
        in_ready_fsm = 1'b1;
        if (in_valid) begin
          sr_d       = in_data;
          bit_cnt_d  = '0;
          byte_cnt_d = '0;
          state_d    = SHIFT;
        end
      end

      SHIFT: begin
        if (sym_ready) begin
          enc_adv   = 1'b1;
          sr_d      = sr_q << 1;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            // bit_cnt wraps to 0 here, which is also where TAIL counts from.
            if (byte_cnt_q == LAST_BYTE) begin
              state_d = TAIL;
            end else begin
              // Handoff: take the next byte on the same edge as the last bit
              // so consecutive bytes stream without a bubble.
              in_ready_fsm = 1'b1;
              if (in_valid) begin
                sr_d       = in_data;
                byte_cnt_d = byte_cnt_q + BCW'(1);
              end else begin
                state_d = WAIT;
              end
            end
          end
        end
      end

      WAIT: begin
        in_ready_fsm = 1'b1;
        if (in_valid) begin
          sr_d       = in_data;
          byte_cnt_d = byte_cnt_q + BCW'(1);
          state_d    = SHIFT;
        end
      end

      TAIL: begin
        if (sym_ready) begin
          enc_adv   = 1'b1;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd1) begin
            // Two zero inputs have flushed the memory back to 00.
            bit_cnt_d = '0;
            state_d   = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Encoder core
  // ---------------------------------------------------------------------
  assign in_tail = (state_q == TAIL);

  conv_enc_core #(
    .G0 (G0),
    .G1 (G1)
  ) u_core (
    .clk     (clk),
    .rst_n   (rst_n),
    .bit_in  (sr_q[7]),
    .zero_in (in_tail),
    .adv     (enc_adv),
    .sym     (sym_out)
  );

  // ---------------------------------------------------------------------
  // Outputs: all symbol-side flags come from registered state only.
  // ---------------------------------------------------------------------
  assign sym_valid = (state_q == SHIFT) || (state_q == TAIL);
  assign sym_sof   = (state_q == SHIFT) && (bit_cnt_q == 3'd0) && (byte_cnt_q == '0);
  assign sym_eof   = (state_q == TAIL) && (bit_cnt_q == 3'd1);
  assign busy      = (state_q != IDLE);

  // IDLE advertises ready, so gate with the reset pin to keep it low while held in reset.
  assign in_ready  = in_ready_fsm & rst_n;

endmodule

// File: tb/tb_conv_encoder_framer.sv
module tb_conv_encoder_framer;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // Instance a: FRAME_BYTES=1
  logic [7:0] a_in_data;
  logic       a_in_valid, a_in_ready, a_sym_ready;
  logic [1:0] a_sym_out;
  logic       a_sym_valid, a_sym_sof, a_sym_eof, a_busy;

  // Instance b: FRAME_BYTES=2
  logic [7:0] b_in_data;
  logic       b_in_valid, b_in_ready, b_sym_ready;
  logic [1:0] b_sym_out;
  logic       b_sym_valid, b_sym_sof, b_sym_eof, b_busy;

  conv_encoder_framer #(.FRAME_BYTES(1)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .sym_ready(a_sym_ready), .sym_out(a_sym_out), .sym_valid(a_sym_valid),
    .sym_sof(a_sym_sof), .sym_eof(a_sym_eof), .busy(a_busy)
  );

  conv_encoder_framer #(.FRAME_BYTES(2)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .sym_ready(b_sym_ready), .sym_out(b_sym_out), .sym_valid(b_sym_valid),
    .sym_sof(b_sym_sof), .sym_eof(b_sym_eof), .busy(b_busy)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Hand-computed symbol streams (first symbol in the top bits).
  // 0xB0, state 00: 11 10 00 01 01 11 00 00, tail 00 00
  // 0xB0 then 0xFF: ... 11 01 10 10 10 10 10 10, tail 01 11
  logic [19:0] exp1;
  logic [35:0] exp2;

  // Transfer recorders, sampled on the falling edge.
  logic [1:0] a_q[$];
  logic       a_sof_q[$], a_eof_q[$];
  logic [1:0] b_q[$];
  logic       b_sof_q[$], b_eof_q[$];
  int         b_rdy_idx[$];
  int         b_bubbles;

  always @(negedge clk) begin
    if (a_sym_valid && a_sym_ready) begin
      a_q.push_back(a_sym_out);
      a_sof_q.push_back(a_sym_sof);
      a_eof_q.push_back(a_sym_eof);
    end
    if (b_busy && b_in_ready) b_rdy_idx.push_back(b_q.size());
    if (b_busy && !b_sym_valid) b_bubbles++;
    if (b_sym_valid && b_sym_ready) begin
      b_q.push_back(b_sym_out);
      b_sof_q.push_back(b_sym_sof);
      b_eof_q.push_back(b_sym_eof);
    end
  end

  task automatic clear_a();
    a_q.delete(); a_sof_q.delete(); a_eof_q.delete();
  endtask

  task automatic clear_b();
    b_q.delete(); b_sof_q.delete(); b_eof_q.delete(); b_rdy_idx.delete();
    b_bubbles = 0;
  endtask

  // Present a byte to instance a and hold it until accepted.
  task automatic offer_a(input logic [7:0] d, output logic ok);
    ok = 1'b0;
    @(posedge clk); #1;
    a_in_data  = d;
    a_in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (a_in_ready) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    a_in_valid = 1'b0;
  endtask

  task automatic offer_b(input logic [7:0] d, input logic keep_valid, output logic ok);
    ok = 1'b0;
    b_in_data  = d;
    b_in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (b_in_ready) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    if (!keep_valid) b_in_valid = 1'b0;
  endtask

  task automatic wait_a(input int n, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      if (a_q.size() >= n) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_b(input int n, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      if (b_q.size() >= n) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    a_in_data = 8'h00; a_in_valid = 1'b0; a_sym_ready = 1'b1;
    b_in_data = 8'h00; b_in_valid = 1'b0; b_sym_ready = 1'b1;
    #12;
    n_cmp++; if (a_sym_valid !== 1'b0) begin n_fail++; $display("FAIL reset_a_sym_valid got=%b exp=0", a_sym_valid); end
    n_cmp++; if (a_sym_sof !== 1'b0) begin n_fail++; $display("FAIL reset_a_sym_sof got=%b exp=0", a_sym_sof); end
    n_cmp++; if (a_sym_eof !== 1'b0) begin n_fail++; $display("FAIL reset_a_sym_eof got=%b exp=0", a_sym_eof); end
    n_cmp++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL reset_a_busy got=%b exp=0", a_busy); end
    n_cmp++; if (a_sym_out !== 2'b00) begin n_fail++; $display("FAIL reset_a_sym_out got=%b exp=00", a_sym_out); end
    n_cmp++; if (a_in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_a_in_ready got=%b exp=0", a_in_ready); end
    n_cmp++; if (b_in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_b_in_ready got=%b exp=0", b_in_ready); end
    n_cmp++; if (b_sym_valid !== 1'b0) begin n_fail++; $display("FAIL reset_b_sym_valid got=%b exp=0", b_sym_valid); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL idle_a_in_ready got=%b exp=1", a_in_ready); end
  endtask

  // FRAME_BYTES=1, 0xB0, no backpressure.
  task automatic test_single_frame();
    logic ok;
    clear_a();
    a_sym_ready = 1'b1;
    offer_a(8'hB0, ok);
    n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL single_accept timeout got=%b exp=1", ok); end
    @(negedge clk);
    n_cmp++; if (a_sym_valid !== 1'b1) begin n_fail++; $display("FAIL single_latency_valid got=%b exp=1", a_sym_valid); end
    n_cmp++; if (a_sym_sof !== 1'b1) begin n_fail++; $display("FAIL single_latency_sof got=%b exp=1", a_sym_sof); end
    wait_a(10, ok);
    n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL single_symbols timeout got=%0d exp=10", a_q.size()); end
    @(negedge clk);
    n_cmp++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_after got=%b exp=0", a_busy); end
    n_cmp++; if (a_sym_valid !== 1'b0) begin n_fail++; $display("FAIL single_valid_after got=%b exp=0", a_sym_valid); end
    n_cmp++; if (a_q.size() !== 10) begin n_fail++; $display("FAIL single_count got=%0d exp=10", a_q.size()); end
    for (int i = 0; i < 10 && i < a_q.size(); i++) begin
      n_cmp++; if (a_q[i] !== exp1[19-2*i -: 2]) begin n_fail++; $display("FAIL single_sym[%0d] got=%b exp=%b", i, a_q[i], exp1[19-2*i -: 2]); end
      n_cmp++; if (a_sof_q[i] !== (i == 0)) begin n_fail++; $display("FAIL single_sof[%0d] got=%b exp=%b", i, a_sof_q[i], (i == 0)); end
      n_cmp++; if (a_eof_q[i] !== (i == 9)) begin n_fail++; $display("FAIL single_eof[%0d] got=%b exp=%b", i, a_eof_q[i], (i == 9)); end
    end
  endtask

  task automatic check_b_stream(input string tag);
    n_cmp++; if (b_q.size() !== 18) begin n_fail++; $display("FAIL %s_count got=%0d exp=18", tag, b_q.size()); end
    for (int i = 0; i < 18 && i < b_q.size(); i++) begin
      n_cmp++; if (b_q[i] !== exp2[35-2*i -: 2]) begin n_fail++; $display("FAIL %s_sym[%0d] got=%b exp=%b", tag, i, b_q[i], exp2[35-2*i -: 2]); end
      n_cmp++; if (b_sof_q[i] !== (i == 0)) begin n_fail++; $display("FAIL %s_sof[%0d] got=%b exp=%b", tag, i, b_sof_q[i], (i == 0)); end
      n_cmp++; if (b_eof_q[i] !== (i == 17)) begin n_fail++; $display("FAIL %s_eof[%0d] got=%b exp=%b", tag, i, b_eof_q[i], (i == 17)); end
    end
  endtask

  // FRAME_BYTES=2, second byte already waiting at the handoff.
  task automatic test_back_to_back();
    logic ok;
    clear_b();
    b_sym_ready = 1'b1;
    @(posedge clk); #1;
    offer_b(8'hB0, 1'b1, ok);
    n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL b2b_accept0 timeout got=%b exp=1", ok); end
    offer_b(8'hFF, 1'b0, ok);
    n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL b2b_accept1 timeout got=%b exp=1", ok); end
    wait_b(18, ok);
    n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL b2b_symbols timeout got=%0d exp=18", b_q.size()); end
    @(negedge clk);
    n_cmp++; if (b_busy !== 1'b0) begin n_fail++; $display("FAIL b2b_busy_after got=%b exp=0", b_busy); end
    n_cmp++; if (b_bubbles !== 0) begin n_fail++; $display("FAIL b2b_bubbles got=%0d exp=0", b_bubbles); end
    n_cmp++; if (b_rdy_idx.size() !== 1) begin n_fail++; $display("FAIL b2b_ready_pulses got=%0d exp=1", b_rdy_idx.size()); end
    if (b_rdy_idx.size() > 0) begin
      n_cmp++; if (b_rdy_idx[0] !== 7) begin n_fail++; $display("FAIL b2b_ready_at got=%0d exp=7", b_rdy_idx[0]); end
    end
    check_b_stream("b2b");
  endtask

  // FRAME_BYTES=2, second byte arrives 5 cycles late.
  task automatic test_wait();
    logic ok;
    clear_b();
    b_sym_ready = 1'b1;
    @(posedge clk); #1;
    offer_b(8'hB0, 1'b0, ok);
    n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL wait_accept0 timeout got=%b exp=1", ok); end
    wait_b(8, ok);
    n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL wait_byte0 timeout got=%0d exp=8", b_q.size()); end
    repeat (4) @(posedge clk);
    #1;
    b_in_data  = 8'hFF;
    b_in_valid = 1'b1;
    @(negedge clk);
    n_cmp++; if (b_in_ready !== 1'b1) begin n_fail++; $display("FAIL wait_in_ready got=%b exp=1", b_in_ready); end
    n_cmp++; if (b_sym_valid !== 1'b0) begin n_fail++; $display("FAIL wait_sym_valid got=%b exp=0", b_sym_valid); end
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    wait_b(18, ok);
    n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL wait_symbols timeout got=%0d exp=18", b_q.size()); end
    @(negedge clk);
    n_cmp++; if (b_bubbles !== 5) begin n_fail++; $display("FAIL wait_bubbles got=%0d exp=5", b_bubbles); end
    check_b_stream("wait");
  endtask

  // FRAME_BYTES=1 with sym_ready toggling.
  task automatic test_stall();
    logic       ok;
    logic       hold;
    logic [1:0] held;
    int         stalls;
    clear_a();
    a_sym_ready = 1'b1;
    hold = 1'b0; held = 2'b00; stalls = 0; ok = 1'b0;
    offer_a(8'hB0, ok);
    n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL stall_accept timeout got=%b exp=1", ok); end
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (hold) begin
        n_cmp++; if (a_sym_out !== held) begin n_fail++; $display("FAIL stall_hold cycle=%0d got=%b exp=%b", i, a_sym_out, held); end
      end
      hold = a_sym_valid && !a_sym_ready;
      held = a_sym_out;
      if (hold) stalls++;
      @(posedge clk);
      if (a_q.size() >= 10) begin ok = 1'b1; break; end
      #1;
      a_sym_ready = (i % 3 == 1) ? 1'b0 : 1'($urandom_range(0, 1));
    end
    #1 a_sym_ready = 1'b1;
    n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL stall_symbols timeout got=%0d exp=10", a_q.size()); end
    n_cmp++; if (stalls < 1) begin n_fail++; $display("FAIL stall_exercised got=%0d exp>=1", stalls); end
    n_cmp++; if (a_q.size() !== 10) begin n_fail++; $display("FAIL stall_count got=%0d exp=10", a_q.size()); end
    for (int i = 0; i < 10 && i < a_q.size(); i++) begin
      n_cmp++; if (a_q[i] !== exp1[19-2*i -: 2]) begin n_fail++; $display("FAIL stall_sym[%0d] got=%b exp=%b", i, a_q[i], exp1[19-2*i -: 2]); end
    end
    n_cmp++; if (a_eof_q.size() == 10 && a_eof_q[9] !== 1'b1) begin n_fail++; $display("FAIL stall_eof got=%b exp=1", a_eof_q[9]); end
  endtask

  // Reset between edges after the 4th symbol, then a clean frame.
  task automatic test_async_reset();
    logic ok;
    clear_a();
    a_sym_ready = 1'b1;
    offer_a(8'hB0, ok);
    n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL areset_accept timeout got=%b exp=1", ok); end
    wait_a(4, ok);
    n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL areset_symbols timeout got=%0d exp=4", a_q.size()); end
    #3;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (a_sym_valid !== 1'b0) begin n_fail++; $display("FAIL areset_sym_valid got=%b exp=0", a_sym_valid); end
    n_cmp++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL areset_busy got=%b exp=0", a_busy); end
    n_cmp++; if (a_sym_out !== 2'b00) begin n_fail++; $display("FAIL areset_sym_out got=%b exp=00", a_sym_out); end
    n_cmp++; if (a_sym_sof !== 1'b0 || a_sym_eof !== 1'b0) begin n_fail++; $display("FAIL areset_sof_eof got=%b%b exp=00", a_sym_sof, a_sym_eof); end
    n_cmp++; if (a_in_ready !== 1'b0) begin n_fail++; $display("FAIL areset_in_ready got=%b exp=0", a_in_ready); end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL areset_no_tail_busy got=%b exp=0", a_busy); end
    n_cmp++; if (a_q.size() !== 4) begin n_fail++; $display("FAIL areset_no_tail_count got=%0d exp=4", a_q.size()); end
    test_single_frame();
  endtask

  initial begin
    exp1 = 20'b11_10_00_01_01_11_00_00_00_00;
    exp2 = 36'b11_10_00_01_01_11_00_00_11_01_10_10_10_10_10_10_01_11;
    b_bubbles = 0;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_wait();
    test_stall();
    test_async_reset();
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
